// File: rtl/vga_screen_mux_if.sv
// vga_screen_mux_if -- bundle of VGA source and output signals for vga_screen_mux.
//
// Purpose: groups the per-source VGA timing/pixel inputs, the screen request,
// and the registered output bundle plus status into one interface.
//
// Signals:
//   sel_req      requested screen index (master -> mux)
//   src_hcount   per-source horizontal counter, N_SRC x HV_W
//   src_vcount   per-source vertical counter, N_SRC x HV_W
//   src_hsync/src_hblnk/src_vsync/src_vblnk  per-source sync/blank flags
//   src_rgb      per-source pixel colour, N_SRC x RGB_W
//   out_*        registered VGA bundle of the applied source (mux -> master)
//   sel_cur      currently applied source index
//   busy         high while a switch is pending or blanking
//   switch_done  one-cycle pulse when a switch completes
//
// Modports: master drives sources and the request; slave is the mux.

interface vga_screen_mux_if #(
  parameter int N_SRC = 3,
  parameter int HV_W  = 11,
  parameter int RGB_W = 12
);
  localparam int SEL_W = $clog2(N_SRC);

  logic [SEL_W-1:0]             sel_req;
  logic [N_SRC-1:0][HV_W-1:0]   src_hcount;
  logic [N_SRC-1:0][HV_W-1:0]   src_vcount;
  logic [N_SRC-1:0]             src_hsync;
  logic [N_SRC-1:0]             src_hblnk;
  logic [N_SRC-1:0]             src_vsync;
  logic [N_SRC-1:0]             src_vblnk;
  logic [N_SRC-1:0][RGB_W-1:0]  src_rgb;

  logic [HV_W-1:0]              out_hcount;
  logic [HV_W-1:0]              out_vcount;
  logic                         out_hsync;
  logic                         out_hblnk;
  logic                         out_vsync;
  logic                         out_vblnk;
  logic [RGB_W-1:0]             out_rgb;
  logic [SEL_W-1:0]             sel_cur;
  logic                         busy;
  logic                         switch_done;

  modport master (
    output sel_req, src_hcount, src_vcount, src_hsync, src_hblnk,
           src_vsync, src_vblnk, src_rgb,
    input  out_hcount, out_vcount, out_hsync, out_hblnk, out_vsync,
           out_vblnk, out_rgb, sel_cur, busy, switch_done
  );

  modport slave (
    input  sel_req, src_hcount, src_vcount, src_hsync, src_hblnk,
           src_vsync, src_vblnk, src_rgb,
    output out_hcount, out_vcount, out_hsync, out_hblnk, out_vsync,
           out_vblnk, out_rgb, sel_cur, busy, switch_done
  );
endinterface

// File: rtl/vga_screen_mux.sv
// vga_screen_mux -- frame-synchronous selector between N_SRC VGA screens.
//
// Purpose: forwards the VGA bundle of the applied source with one cycle of
// register latency. A new screen request is only applied on a rising edge of
// the applied source's vblank, after which BLANK_FRAMES black frames of the
// new source are emitted before normal pixels resume.
//
// Ports:
//   clk_40  the only clock, rising edge
//   rst     synchronous, active-high reset
//   bus     vga_screen_mux_if.slave: sources, request, outputs, status
//
// Parameters:
//   N_SRC (2..8), HV_W, RGB_W, BLANK_FRAMES (0..15)

module vga_screen_mux #(
  parameter int N_SRC        = 3,
  parameter int HV_W         = 11,
  parameter int RGB_W        = 12,
  parameter int BLANK_FRAMES = 1
) (
  input  logic             clk_40,
  input  logic             rst,
  vga_screen_mux_if.slave  bus
);

  localparam int              SEL_W     = $clog2(N_SRC);
  localparam logic [SEL_W:0]  N_SRC_L   = N_SRC[SEL_W:0];
  localparam int              BF_LAST_I = (BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0;
  localparam logic [3:0]      BF_LAST   = BF_LAST_I[3:0];

  typedef enum logic [1:0] {
    SHOW    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] sel_eff;
  logic [SEL_W-1:0] sel_cur_q;
  logic             vblnk_q;
  logic [3:0]       frame_cnt;
  logic             frame_edge;
  logic             do_switch;
  logic             done_nx;
  logic             cnt_clr;
  logic             cnt_inc;

  // Out-of-range requests fall back to screen 0.
  assign sel_eff = ({1'b0, bus.sel_req} >= N_SRC_L) ? '0 : bus.sel_req;

  // Frame edge = rising vblank of the applied source.
  assign frame_edge = bus.src_vblnk[sel_cur_q] & ~vblnk_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_40) begin
    if (rst) state <= SHOW;
    else     state <= state_nx;
  end

  // Next-state and control decode.
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nx  = state;
    do_switch = 1'b0;
    done_nx   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      SHOW: begin
        // A request seen on a frame edge still waits for the next edge,
        // since the edge is only acted on from PENDING.
        if (sel_eff != sel_cur_q) state_nx = PENDING;
      end
      PENDING: begin
        if (sel_eff == sel_cur_q) begin
          state_nx = SHOW;                  // request withdrawn
        end else if (frame_edge) begin
          do_switch = 1'b1;
          if (BLANK_FRAMES == 0) begin
            state_nx = SHOW;
            done_nx  = 1'b1;
          end else begin
            state_nx = BLANK;
            cnt_clr  = 1'b1;
          end
        end
      end
      BLANK: begin
        // Request changes are ignored here; SHOW picks them up afterwards.
        if (frame_edge) begin
          cnt_inc = 1'b1;
          if (frame_cnt == BF_LAST) begin
            state_nx = SHOW;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = SHOW;
    endcase
  end

  // Datapath: output bundle, applied index, edge detector, frame counter.
  always_ff @(posedge clk_40) begin
    if (rst) begin
      sel_cur_q       <= '0;
      vblnk_q         <= 1'b0;
      frame_cnt       <= '0;
      bus.switch_done <= 1'b0;
      bus.out_hcount  <= '0;
      bus.out_vcount  <= '0;
      bus.out_hsync   <= 1'b0;
      bus.out_hblnk   <= 1'b0;
      bus.out_vsync   <= 1'b0;
      bus.out_vblnk   <= 1'b0;
      bus.out_rgb     <= '0;
    end else begin
      bus.out_hcount  <= bus.src_hcount[sel_cur_q];
      bus.out_vcount  <= bus.src_vcount[sel_cur_q];
      bus.out_hsync   <= bus.src_hsync[sel_cur_q];
      bus.out_hblnk   <= bus.src_hblnk[sel_cur_q];
      bus.out_vsync   <= bus.src_vsync[sel_cur_q];
      bus.out_vblnk   <= bus.src_vblnk[sel_cur_q];
      bus.out_rgb     <= (state == BLANK) ? '0 : bus.src_rgb[sel_cur_q];
      bus.switch_done <= done_nx;

      if (do_switch) begin
        sel_cur_q <= sel_eff;
        // Prime the detector with the new source's level so its current
        // vblank state does not read as an edge next cycle.
        vblnk_q   <= bus.src_vblnk[sel_eff];
      end else begin
        vblnk_q   <= bus.src_vblnk[sel_cur_q];
      end

      if (cnt_clr)      frame_cnt <= '0;
      else if (cnt_inc) frame_cnt <= frame_cnt + 4'd1;
    end
  end

  assign bus.sel_cur = sel_cur_q;
  assign bus.busy    = (state != SHOW);

endmodule

// File: tb/tb_vga_screen_mux.sv
// tb_vga_screen_mux -- randomized scoreboard bench for vga_screen_mux.
//
// Three DUT copies (BLANK_FRAMES = 0, 1, 2) share the same three synthetic
// VGA sources, request and reset. A reference model tracks, per copy, the
// screen on display, whether a switch is waiting or blanking, and how many
// black frames remain; the driver pushes its prediction for every clock and
// a monitor compares at the falling edge.

module tb_vga_screen_mux;

  localparam int NS    = 3;
  localparam int HV_W  = 11;
  localparam int RGB_W = 12;
  localparam int NK    = 3;       // copies, BLANK_FRAMES = index
  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int V_TOT = 6;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] sel_req;
  logic [NS-1:0][HV_W-1:0]  s_hc, s_vc;
  logic [NS-1:0]            s_hs, s_hb, s_vs, s_vb;
  logic [NS-1:0][RGB_W-1:0] s_rgb;

  logic [NK-1:0][25:0]      o_tim;
  logic [NK-1:0][RGB_W-1:0] o_rgb;
  logic [NK-1:0][1:0]       o_sel;
  logic [NK-1:0]            o_busy, o_done;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NK; k++) begin : g_dut
    vga_screen_mux_if #(.N_SRC(NS), .HV_W(HV_W), .RGB_W(RGB_W)) bus ();
    assign bus.sel_req    = sel_req;
    assign bus.src_hcount = s_hc;
    assign bus.src_vcount = s_vc;
    assign bus.src_hsync  = s_hs;
    assign bus.src_hblnk  = s_hb;
    assign bus.src_vsync  = s_vs;
    assign bus.src_vblnk  = s_vb;
    assign bus.src_rgb    = s_rgb;

    vga_screen_mux #(.N_SRC(NS), .HV_W(HV_W), .RGB_W(RGB_W),
                     .BLANK_FRAMES(k)) dut (
      .clk_40 (clk),
      .rst    (rst),
      .bus    (bus)
    );

    assign o_tim[k]  = {bus.out_hcount, bus.out_vcount, bus.out_hsync,
                        bus.out_hblnk, bus.out_vsync, bus.out_vblnk};
    assign o_rgb[k]  = bus.out_rgb;
    assign o_sel[k]  = bus.sel_cur;
    assign o_busy[k] = bus.busy;
    assign o_done[k] = bus.switch_done;
  end

  // Scoreboard entry: expected DUT outputs after one clock edge.
  typedef struct {
    logic [NK-1:0][25:0]      tim;
    logic [NK-1:0][RGB_W-1:0] rgb;
    logic [NK-1:0][1:0]       sel;
    logic [NK-1:0]            busy;
    logic [NK-1:0]            done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s[bf=%0d] t=%0t: got %h expected %h", name, k, $time, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_SHOW, M_WAIT, M_BLACK} mode_e;
  mode_e m_mode [NK];
  int    m_cur  [NK];
  bit    m_prev [NK];   // last seen vblank level of the displayed screen
  int    m_left [NK];   // black frames still to emit

  task automatic model(output exp_t e);
    int  want;
    bit  rise;
    want = (int'(sel_req) >= NS) ? 0 : int'(sel_req);
    for (int k = 0; k < NK; k++) begin
      e.done[k] = 1'b0;
      if (rst) begin
        m_mode[k] = M_SHOW; m_cur[k] = 0; m_prev[k] = 1'b0; m_left[k] = 0;
        e.tim[k] = '0; e.rgb[k] = '0;
      end else begin
        int c;
        c = m_cur[k];
        e.tim[k] = {s_hc[c], s_vc[c], s_hs[c], s_hb[c], s_vs[c], s_vb[c]};
        e.rgb[k] = (m_mode[k] == M_BLACK) ? '0 : s_rgb[c];
        rise      = s_vb[c] && !m_prev[k];
        m_prev[k] = s_vb[c];
        if (m_mode[k] == M_SHOW) begin
          if (want != c) m_mode[k] = M_WAIT;
        end else if (m_mode[k] == M_WAIT) begin
          if (want == c) m_mode[k] = M_SHOW;
          else if (rise) begin
            m_cur[k]  = want;
            m_prev[k] = s_vb[want];
            if (k == 0) begin
              m_mode[k] = M_SHOW; e.done[k] = 1'b1;
            end else begin
              m_mode[k] = M_BLACK; m_left[k] = k;
            end
          end
        end else if (rise) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_mode[k] = M_SHOW; e.done[k] = 1'b1;
          end
        end
      end
      e.sel[k]  = 2'(m_cur[k]);
      e.busy[k] = (m_mode[k] != M_SHOW);
    end
  endtask

  // ---------------- sources and driver ----------------
  int hc [NS];
  int vc [NS];
  bit abc_mode = 1'b0;

  task automatic step();
    exp_t e;
    for (int i = 0; i < NS; i++) begin
      s_hc[i]  = 11'(hc[i]);
      s_vc[i]  = 11'(vc[i]);
      s_hb[i]  = (hc[i] >= H_ACT);
      s_hs[i]  = (hc[i] == 10 + i - 1);
      s_vb[i]  = (vc[i] >= V_ACT);
      s_vs[i]  = (vc[i] == V_TOT - 1);
      s_rgb[i] = (abc_mode && i == 0) ? 12'hABC : 12'($urandom);
    end
    model(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      hc[i]++;
      if (hc[i] == 10 + i) begin
        hc[i] = 0;
        vc[i] = (vc[i] + 1) % V_TOT;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NK; k++) begin
          check("timing",      k, 32'(o_tim[k]),  32'(e.tim[k]));
          check("out_rgb",     k, 32'(o_rgb[k]),  32'(e.rgb[k]));
          check("sel_cur",     k, 32'(o_sel[k]),  32'(e.sel[k]));
          check("busy",        k, 32'(o_busy[k]), 32'(e.busy[k]));
          check("switch_done", k, 32'(o_done[k]), 32'(e.done[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    for (int i = 0; i < NS; i++) begin
      hc[i] = $urandom_range(0, 9 + i);
      vc[i] = $urandom_range(0, V_TOT - 1);
    end
    rst     = 1'b1;
    sel_req = 2'd0;
    run(3);
    rst = 1'b0;

    // Passthrough of a fixed colour from source 0.
    abc_mode = 1'b1;
    run(100);
    abc_mode = 1'b0;

    // Switch 0 -> 1 (blanked for bf > 0), then 1 -> 2.
    sel_req = 2'd1;
    run(250);
    sel_req = 2'd2;
    run(250);

    // Back to 0, then a request withdrawn well before any frame edge.
    sel_req = 2'd0;
    run(250);
    guard = 0;
    while (vc[0] != 0 && guard < 200) begin
      step();
      guard++;
    end
    check("cancel_align", 0, 32'(vc[0]), 32'd0);
    sel_req = 2'd2;
    run(3);
    sel_req = 2'd0;
    run(100);

    // Out-of-range request from screen 1 falls back to 0.
    sel_req = 2'd1;
    run(250);
    sel_req = 2'd3;
    run(250);

    // Reset in the middle of a blanking interval.
    sel_req = 2'd2;
    guard = 0;
    while (m_mode[1] != M_BLACK && guard < 400) begin
      step();
      guard++;
    end
    check("reach_blank", 1, 32'(m_mode[1] == M_BLACK), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(300);

    // Random requests with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) == 0) sel_req = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;

    @(negedge clk);
    #1;
    check("drain", 0, 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
